// File: rtl/mp_link_pkg.sv
// Shared frame layout, FSM state encodings and payload struct for the serial player link.
package mp_link_pkg;

  localparam int FRAME_BITS   = 9;  // start + 6 data + parity + stop
  localparam int PAYLOAD_BITS = 6;
  localparam int SCORE_LSB    = 0;
  localparam int PAUSE_BIT    = 4;
  localparam int RELOAD_BIT   = 5;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  typedef struct packed {
    logic       reload;
    logic       pause;
    logic [3:0] score;
  } mp_payload_t;

endpackage

// File: rtl/mp_link_rx.sv
// Receive half of the link: synchroniser, bit-timed deframer and frame validation.
// ok_o / err_o are single-cycle strobes on the stop-sample cycle; data_o holds the payload.
module mp_link_rx
  import mp_link_pkg::*;
#(
  parameter int CLK_DIV = 650
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_i,
  output logic                    ok_o,
  output logic                    err_o,
  output logic [PAYLOAD_BITS-1:0] data_o
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(PAYLOAD_BITS);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(PAYLOAD_BITS - 1);

  logic                    s1_q, s2_q;
  rx_state_t               st_q;
  logic [DW-1:0]           div_q;
  logic [BW-1:0]           bit_q;
  logic [PAYLOAD_BITS-1:0] data_q;
  logic                    par_q;
  logic                    armed_q;  // line seen high since the last bad frame
  logic                    tick, stop_hit;

  // Two-flop synchroniser; idles at the line's mark level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= rx_i;
      s2_q <= s1_q;
    end
  end

  assign tick     = (div_q == DIV_LAST);
  assign stop_hit = (st_q == RX_STOP) && tick;
  assign ok_o     = stop_hit && s2_q && (par_q == ^data_q);
  assign err_o    = stop_hit && !ok_o;
  assign data_o   = data_q;

  // Deframer: half-bit start qualification, then one sample per bit period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= RX_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      case (st_q)
        RX_IDLE: begin
          if (!armed_q) armed_q <= s2_q;
          else if (!s2_q) begin
            st_q  <= RX_START;
            div_q <= '0;
          end
        end
        RX_START: begin
          if (div_q == HALF_LAST) begin
            div_q <= '0;
            bit_q <= '0;
            st_q  <= s2_q ? RX_IDLE : RX_DATA;  // glitch: drop silently
          end else div_q <= div_q + 1'b1;
        end
        RX_DATA: begin
          if (tick) begin
            div_q  <= '0;
            data_q <= {s2_q, data_q[PAYLOAD_BITS-1:1]};  // LSB arrives first
            if (bit_q == BIT_LAST) st_q <= RX_PARITY;
            else bit_q <= bit_q + 1'b1;
          end else div_q <= div_q + 1'b1;
        end
        RX_PARITY: begin
          if (tick) begin
            div_q <= '0;
            par_q <= s2_q;
            st_q  <= RX_STOP;
          end else div_q <= div_q + 1'b1;
        end
        RX_STOP: begin
          if (tick) begin
            div_q   <= '0;
            st_q    <= RX_IDLE;
            armed_q <= ok_o;  // after a bad frame, wait for mark before next start
          end else div_q <= div_q + 1'b1;
        end
        default: st_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mp_link.sv
// Two-board player link: periodic TX heartbeat of local status, RX of peer status,
// reload capture between frames and a peer-presence timeout.
module mp_link
  import mp_link_pkg::*;
#(
  parameter int CLK_DIV      = 650,
  parameter int FRAME_PERIOD = 65000,
  parameter int TIMEOUT      = 650000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] player1_score,
  input  logic       player1_pause,
  input  logic       player1_reload,
  output logic       link_tx,
  input  logic       link_rx,
  output logic [3:0] player2_score,
  output logic       player2_pause,
  output logic       player2_reload,
  output logic       player2_connected,
  output logic       frame_error
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int PW = $clog2(FRAME_PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);  // must be able to hold TIMEOUT itself
  localparam int BW = $clog2(PAYLOAD_BITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(FRAME_PERIOD - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(PAYLOAD_BITS - 1);

  logic [PW-1:0]           per_q;
  tx_state_t               tx_st_q;
  logic [DW-1:0]           div_q;
  logic [BW-1:0]           bit_q;
  logic [PAYLOAD_BITS-1:0] sh_q;
  logic                    par_q, tx_q;
  logic                    pend_q, pend_d;
  logic                    snap;
  mp_payload_t             snap_pl;

  logic [TW-1:0]           to_q;
  logic [3:0]              p2_score_q;
  logic                    p2_pause_q, p2_reload_q, p2_conn_q, ferr_q;
  logic                    rx_ok, rx_err;
  logic [PAYLOAD_BITS-1:0] rx_data;

  assign snap = (tx_st_q == TX_IDLE) && (per_q == PER_LAST);

  // Payload as captured at frame start; a reload arriving on the snapshot cycle still rides along.
  always_comb begin
    snap_pl        = '0;
    snap_pl.score  = player1_score;
    snap_pl.pause  = player1_pause;
    snap_pl.reload = pend_q | player1_reload;
  end

  assign pend_d = snap ? 1'b0 : (pend_q | player1_reload);

  // Free-running frame period counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  per_q <= '0;
    else if (per_q == PER_LAST) per_q <= '0;
    else                       per_q <= per_q + 1'b1;
  end

  // Holds a short reload pulse until the next frame picks it up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_q <= 1'b0;
    else      pend_q <= pend_d;
  end

  // TX framer; tx_q is the registered line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_st_q <= TX_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      case (tx_st_q)
        TX_IDLE: begin
          if (snap) begin
            sh_q    <= snap_pl;
            par_q   <= ^snap_pl;
            tx_q    <= 1'b0;
            div_q   <= '0;
            tx_st_q <= TX_START;
          end
        end
        TX_START: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= sh_q[0];
            tx_st_q <= TX_DATA;
          end else div_q <= div_q + 1'b1;
        end
        TX_DATA: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (bit_q == BIT_LAST) begin
              tx_q    <= par_q;
              tx_st_q <= TX_PARITY;
            end else begin
              bit_q <= bit_q + 1'b1;
              tx_q  <= sh_q[1];
              sh_q  <= {1'b0, sh_q[PAYLOAD_BITS-1:1]};
            end
          end else div_q <= div_q + 1'b1;
        end
        TX_PARITY: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            tx_q    <= 1'b1;
            tx_st_q <= TX_STOP;
          end else div_q <= div_q + 1'b1;
        end
        TX_STOP: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            tx_st_q <= TX_IDLE;
          end else div_q <= div_q + 1'b1;
        end
        default: tx_st_q <= TX_IDLE;
      endcase
    end
  end

  mp_link_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk    (clk),
    .rst    (rst),
    .rx_i   (link_rx),
    .ok_o   (rx_ok),
    .err_o  (rx_err),
    .data_o (rx_data)
  );

  // Peer status registers and heartbeat timeout; a valid frame always wins over expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_q        <= '0;
      p2_score_q  <= '0;
      p2_pause_q  <= 1'b0;
      p2_reload_q <= 1'b0;
      p2_conn_q   <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      p2_reload_q <= 1'b0;
      ferr_q      <= rx_err;
      if (rx_ok) begin
        p2_score_q  <= rx_data[SCORE_LSB +: 4];
        p2_pause_q  <= rx_data[PAUSE_BIT];
        p2_reload_q <= rx_data[RELOAD_BIT];
        p2_conn_q   <= 1'b1;
        to_q        <= '0;
      end else if (to_q != TO_MAX) begin
        to_q <= to_q + 1'b1;
        if (to_q == TO_LAST) begin
          p2_conn_q  <= 1'b0;
          p2_score_q <= '0;
          p2_pause_q <= 1'b0;
        end
      end
    end
  end

  assign link_tx           = tx_q;
  assign player2_score     = p2_score_q;
  assign player2_pause     = p2_pause_q;
  assign player2_reload    = p2_reload_q;
  assign player2_connected = p2_conn_q;
  assign frame_error       = ferr_q;

endmodule

// File: tb/tb_mp_link.sv
// Loopback and directly-driven checks of mp_link with small timing parameters.
module tb_mp_link;

  localparam int CLK_DIV      = 8;
  localparam int FRAME_PERIOD = 200;
  localparam int TIMEOUT      = 1000;
  localparam int WIN          = 9 * CLK_DIV + 2;

  logic       clk = 1'b0, rst = 1'b0;
  logic [3:0] p1_score = '0;
  logic       p1_pause = 1'b0, p1_reload = 1'b0;
  logic       link_tx, link_rx;
  logic       rx_drv = 1'b1, loop = 1'b1;
  logic [3:0] p2_score;
  logic       p2_pause, p2_reload, p2_conn, ferr;

  int errors = 0, checks = 0;
  int cyc = 0, rl_cnt = 0, fe_cnt = 0;

  typedef struct {
    logic [3:0] sc; logic pa; logic rl;
    logic [3:0] e_sc; logic e_pa; int e_rl;
  } vec_t;
  typedef struct { logic [3:0] sc; logic pa; int rl; } exp_t;

  vec_t vecs[6];
  exp_t sb[$];

  mp_link #(.CLK_DIV(CLK_DIV), .FRAME_PERIOD(FRAME_PERIOD), .TIMEOUT(TIMEOUT)) dut (
    .clk               (clk),
    .rst               (rst),
    .player1_score     (p1_score),
    .player1_pause     (p1_pause),
    .player1_reload    (p1_reload),
    .link_tx           (link_tx),
    .link_rx           (link_rx),
    .player2_score     (p2_score),
    .player2_pause     (p2_pause),
    .player2_reload    (p2_reload),
    .player2_connected (p2_conn),
    .frame_error       (ferr)
  );

  always #5 clk = ~clk;
  assign link_rx = loop ? link_tx : rx_drv;

  always @(posedge clk) cyc <= cyc + 1;

  // Count high samples of the pulse outputs; a 1-cycle pulse adds exactly one.
  always @(negedge clk) begin
    if (p2_reload === 1'b1) rl_cnt <= rl_cnt + 1;
    if (ferr === 1'b1)      fe_cnt <= fe_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_fall(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (link_tx !== 1'b0 && n < 400);
    if (n >= 400) chk("tx_frame_start_timeout", 0, 1);
  endtask

  task automatic push_exp(input logic [3:0] sc, input logic pa, input int rl);
    exp_t e;
    e.sc = sc; e.pa = pa; e.rl = rl;
    sb.push_back(e);
  endtask

  // Called at the frame start; pops the expected result once the frame has had time to land.
  task automatic run_window(input string nm);
    exp_t e;
    int r0, f0;
    r0 = rl_cnt; f0 = fe_cnt;
    repeat (WIN) @(negedge clk);
    if (sb.size() == 0) begin chk({nm, " scoreboard_empty"}, 0, 1); return; end
    e = sb.pop_front();
    chk({nm, " p2_score"}, p2_score, e.sc);
    chk({nm, " p2_pause"}, p2_pause, e.pa);
    chk({nm, " p2_connected"}, p2_conn, 1);
    chk({nm, " reload_pulses"}, rl_cnt - r0, e.rl);
    chk({nm, " frame_error_pulses"}, fe_cnt - f0, 0);
  endtask

  task automatic send_frame(input logic [5:0] d, input bit flip);
    logic [8:0] f;
    f = {1'b1, (^d) ^ flip, d, 1'b0};
    for (int b = 0; b < 9; b++) begin
      rx_drv = f[b];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    int n, r0, f0, t0, t1;
    logic [3:0] sc0;
    logic pa0;
    vec_t v;

    vecs[0] = '{4'hA, 1'b1, 1'b0, 4'hA, 1'b1, 0};
    vecs[1] = '{4'h3, 1'b0, 1'b1, 4'h3, 1'b0, 1};
    vecs[2] = '{4'h3, 1'b0, 1'b0, 4'h3, 1'b0, 0};
    vecs[3] = '{4'hF, 1'b1, 1'b1, 4'hF, 1'b1, 1};
    vecs[4] = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 0};
    vecs[5] = '{4'hC, 1'b1, 1'b0, 4'hC, 1'b1, 0};

    repeat (3) @(negedge clk);
    chk("reset link_tx", link_tx, 1);
    chk("reset p2_score", p2_score, 0);
    chk("reset p2_pause", p2_pause, 0);
    chk("reset p2_reload", p2_reload, 0);
    chk("reset p2_connected", p2_conn, 0);
    chk("reset frame_error", ferr, 0);
    rst = 1'b1;

    // Loopback vectors; inputs are scrambled right after each frame start.
    foreach (vecs[i]) begin
      v = vecs[i];
      p1_score = v.sc; p1_pause = v.pa;
      if (v.rl) begin
        repeat (5) @(negedge clk);
        p1_reload = 1'b1;
        @(negedge clk);
        p1_reload = 1'b0;
      end
      push_exp(v.e_sc, v.e_pa, v.e_rl);
      wait_fall(n);
      if (i == 0) chk("first_frame_start_cycles", n, FRAME_PERIOD);
      p1_score = ~v.sc; p1_pause = ~v.pa;
      run_window($sformatf("vec%0d", i));
    end

    // Reload raised exactly on the snapshot cycle: carried now, not repeated next frame.
    p1_score = 4'h6; p1_pause = 1'b0;
    push_exp(4'h6, 1'b0, 0);
    wait_fall(n);
    run_window("pre_coincident");
    repeat (FRAME_PERIOD - 1 - WIN) @(negedge clk);
    p1_reload = 1'b1;
    @(negedge clk);
    p1_reload = 1'b0;
    chk("coincident frame started", link_tx, 0);
    push_exp(4'h6, 1'b0, 1);
    run_window("coincident_reload");
    push_exp(4'h6, 1'b0, 0);
    wait_fall(n);
    run_window("after_coincident");

    // Directly driven line: parity error.
    loop = 1'b0;
    r0 = rl_cnt; f0 = fe_cnt; sc0 = p2_score; pa0 = p2_pause;
    send_frame(6'h19, 1'b1);
    repeat (10) @(negedge clk);
    chk("parity frame_error_pulses", fe_cnt - f0, 1);
    chk("parity p2_score kept", p2_score, sc0);
    chk("parity p2_pause kept", p2_pause, pa0);
    chk("parity reload_pulses", rl_cnt - r0, 0);
    chk("parity p2_connected", p2_conn, 1);

    // False start: 2-cycle low glitch.
    f0 = fe_cnt;
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    chk("false_start frame_error_pulses", fe_cnt - f0, 0);
    chk("false_start p2_score kept", p2_score, sc0);

    // Valid frame after the glitch, then timeout measured from its update.
    f0 = fe_cnt;
    t0 = 0;
    fork
      send_frame(6'h15, 1'b0);
      begin
        int m;
        m = 0;
        do begin @(negedge clk); m++; end while (p2_score !== 4'h5 && m < 150);
        t0 = cyc;
      end
    join
    chk("post_glitch p2_score", p2_score, 5);
    chk("post_glitch p2_pause", p2_pause, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (p2_conn !== 1'b0 && n < 1200);
    t1 = cyc;
    chk("disconnect delay cycles", t1 - t0, TIMEOUT);
    chk("disconnect p2_connected", p2_conn, 0);
    chk("disconnect p2_score", p2_score, 0);
    chk("disconnect p2_pause", p2_pause, 0);
    chk("manual frame_error_pulses", fe_cnt - f0, 0);

    // Reconnect over loopback, switching only while TX is idle.
    wait_fall(n);
    repeat (WIN) @(negedge clk);
    loop = 1'b1;
    push_exp(4'h6, 1'b0, 0);
    wait_fall(n);
    run_window("reconnect");

    // Async reset in the middle of the data bits.
    wait_fall(n);
    repeat (12) @(negedge clk);
    chk("pre_reset link_tx data bit", link_tx, 0);
    #2 rst = 1'b0;
    #1;
    chk("async_reset link_tx", link_tx, 1);
    chk("async_reset p2_score", p2_score, 0);
    chk("async_reset p2_pause", p2_pause, 0);
    chk("async_reset p2_reload", p2_reload, 0);
    chk("async_reset p2_connected", p2_conn, 0);
    chk("async_reset frame_error", ferr, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_fall(n);
    chk("post_reset frame_start_cycles", n, FRAME_PERIOD);
    push_exp(4'h6, 1'b0, 0);
    run_window("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mp_link.md
Name: mp_link

Overview:
- Serial two-board multiplayer link. Replaces the six parallel player-to-player wires with one TX wire and one RX wire.
- TX side: periodically serialises local player1 status (score, pause, reload) into a framed UART-style heartbeat.
- RX side: deserialises the peer's frames into player2_score / player2_pause / player2_reload and derives player2_connected.
- Sits between the board pins and the reload/pause control logic and score overlay.

Parameters:
- CLK_DIV, 650, clk cycles per bit (100 kbit/s at 65 MHz); must be ≥4.
- FRAME_PERIOD, 65000, clk cycles between TX frame starts; must be > 9*CLK_DIV.
- TIMEOUT, 650000, clk cycles without a valid RX frame before the peer is declared disconnected.

Ports:
- clk  in  1  system clock, 65 MHz
- rst  in  1  reset; asynchronous, active-low
- player1_score  in  4  local score, level
- player1_pause  in  1  local pause request, level
- player1_reload  in  1  local reload request, may be a 1-cycle pulse
- link_tx  out  1  serial output, idles high
- link_rx  in  1  serial input, asynchronous to clk
- player2_score  out  4  last valid peer score
- player2_pause  out  1  last valid peer pause
- player2_reload  out  1  1-cycle pulse per valid frame with reload bit set
- player2_connected  out  1  peer heartbeat present
- frame_error  out  1  1-cycle pulse on parity or stop-bit error

Behaviour:
- Reset (rst=0, async): link_tx=1, all other outputs 0, both FSMs idle, all counters 0, reload_pending=0.
- Frame format: 9 bits, LSB first, each bit CLK_DIV cycles long.
  - start=0
  - d[3:0]=score, d[4]=pause, d[5]=reload
  - parity = even parity over d[5:0] (XOR of d[5:0])
  - stop=1
- Reload capture: reload_pending is set by player1_reload=1 and cleared when a payload snapshot is taken. If set and snapshot occur in the same cycle, the snapshot carries reload=1 and pending ends at 0.
- Frame period counter: free-running 0..FRAME_PERIOD-1, wraps.
- TX FSM (TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP):
  - In TX_IDLE, when period count == FRAME_PERIOD-1: snapshot payload and go to TX_START.
  - link_tx drives start low on the next cycle. Bit counter runs 0..5 in TX_DATA.
  - TX_STOP holds link_tx high for CLK_DIV cycles, then returns to TX_IDLE.
  - Inputs changing mid-frame do not affect the frame in flight.
- RX input: link_rx passes through a 2-FF synchroniser (reset value 1). All RX logic uses the synchronised value.
- RX FSM (RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP):
  - RX_IDLE: a synchronised 0 enters RX_START.
  - RX_START: wait CLK_DIV/2 cycles (integer division). If the line is 1, it is a false start: return to RX_IDLE silently, no error.
  - Otherwise sample every CLK_DIV cycles: 6 data bits, then parity, then stop.
  - At the stop sample, the frame is valid iff parity matches and stop=1.
- Valid frame: on the cycle after the stop sample:
  - player2_score and player2_pause are updated.
  - player2_reload pulses high for exactly 1 cycle if d[5]=1.
  - player2_connected=1; timeout counter cleared.
- Invalid frame: frame_error pulses for 1 cycle, outputs unchanged, timeout counter not cleared. FSM returns to RX_IDLE and waits for the line to be high before accepting a new start.
- Timeout counter:
  - Increments each cycle while not saturated, saturating at TIMEOUT.
  - On reaching TIMEOUT: player2_connected=0, player2_score=0, player2_pause=0.
  - Reconnection occurs on the next valid frame.
- Counter widths: $clog2 of the corresponding parameter.
- No TX/RX dependency: the link works with link_tx looped to link_rx.

Decomposition:
- Package mp_link_pkg holds:
  - FRAME_BITS=9, PAYLOAD_BITS=6
  - payload bit indices SCORE_LSB=0, PAUSE_BIT=4, RELOAD_BIT=5
  - enum typedefs tx_state_t and rx_state_t
  - packed struct mp_payload_t {reload, pause, score[3:0]}
- Sub-module: mp_link_rx (synchroniser, RX FSM, frame validation).
- TX, reload capture and timeout remain in mp_link.

Test Plan:
Benches use CLK_DIV=8, FRAME_PERIOD=200, TIMEOUT=1000, with link_tx looped to link_rx unless noted.
- Basic loopback: score=4'hA, pause=1 -> first frame starts at cycle 199. Within 9*8+2 cycles of that start, player2_score=4'hA, player2_pause=1, player2_connected=1, frame_error never asserted.
- Reload pulse: 1-cycle player1_reload pulse mid-period -> exactly one 1-cycle player2_reload pulse after the next frame, none after later frames.
- Parity error: drive link_rx with a frame carrying a flipped parity bit -> one frame_error pulse, player2_* unchanged.
- False start: link_rx low for 2 cycles -> no frame_error, no output change, RX returns idle.
- Disconnect: hold link_rx=1 after connection -> exactly 1000 cycles after the last valid-frame update, player2_connected=0, player2_score=0, player2_pause=0. A subsequent valid frame reconnects.
- Async reset mid-frame: assert rst=0 during TX_DATA -> link_tx=1 and all outputs 0 immediately. After release, the first frame starts at period count 199.
